// File: rtl/addsub_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the sliced adder/subtractor.
// The controller drives the master side and the datapath drives the slave side.
interface addsub_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, sel,
    input  busy, done, s, cout, ovf, zero
  );

  modport slave (
    input  start, a, b, sel,
    output busy, done, s, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor computing one CHUNK-bit slice per clock.
// Result and flags are published together on completion and held until the next one.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst,
  addsub_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] slice_a_s;
  logic [CHUNK-1:0] slice_b_s;
  logic [CHUNK:0]   sum_s;
  logic             last_s;
  logic             msb_cin_s;

  // Subtraction is A + ~B + 1: B is inverted per slice and the initial carry is sel.
  assign slice_a_s = a_q[cnt_q*CHUNK +: CHUNK];
  assign slice_b_s = b_q[cnt_q*CHUNK +: CHUNK] ^ {CHUNK{sel_q}};
  assign sum_s     = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{CHUNK{1'b0}}, carry_q};
  assign last_s    = (cnt_q == CW'(NSLICE - 1));
  // Carry into the top bit of the slice, recovered from its sum bit.
  assign msb_cin_s = sum_s[CHUNK-1] ^ slice_a_s[CHUNK-1] ^ slice_b_s[CHUNK-1];

  // Next-state, slice datapath and completion update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    s_d       = s_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          a_d       = bus.a;
          b_d       = bus.b;
          sel_d     = bus.sel;
          carry_d   = bus.sel;
          cnt_d     = '0;
          partial_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        partial_d[cnt_q*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
        carry_d = sum_s[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          state_d = ST_DONE;
          s_d     = partial_d;
          cout_d  = sum_s[CHUNK];
          ovf_d   = sum_s[CHUNK] ^ msb_cin_s;
          zero_d  = (partial_d == '0);
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      partial_q <= '0;
      s_q       <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      s_q       <= s_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq at CHUNK=4 (directed), CHUNK=1 and CHUNK=16 (model-checked).
// Stimulus pushes expected results and completion cycle; a negedge monitor pops on done.
module tb_addsub_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(16)) if0 ();
  addsub_seq_if #(.WIDTH(16)) if1 ();
  addsub_seq_if #(.WIDTH(16)) if2 ();

  addsub_seq #(.WIDTH(16), .CHUNK(4))  u0 (.clk(clk), .rst(rst), .bus(if0));
  addsub_seq #(.WIDTH(16), .CHUNK(1))  u1 (.clk(clk), .rst(rst), .bus(if1));
  addsub_seq #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] hold_s = 16'h0000;

  logic [15:0] dir_a [0:5] = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h1234, 16'h8000};
  logic [15:0] dir_b [0:5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h8000};
  logic        dir_s [0:5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nsl(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.z = z; e.cyc = 0;
    return e;
  endfunction

  // Reference: 17-bit sum of A and (B or ~B) plus sel; overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sel);
    logic [15:0] bx;
    logic [16:0] r;
    bx = sel ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + {16'h0000, sel};
    return mk(r[15:0], r[16], (a[15] == bx[15]) && (r[15] != a[15]), r[15:0] == 16'h0000);
  endfunction

  task automatic drive(input int d, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic sel);
    case (d)
      0: begin if0.start = st; if0.a = a; if0.b = b; if0.sel = sel; end
      1: begin if1.start = st; if1.a = a; if1.b = b; if1.sel = sel; end
      default: begin if2.start = st; if2.a = a; if2.b = b; if2.sel = sel; end
    endcase
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  // Called at a negedge; start is seen at the next posedge, done expected NSLICE edges later.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input logic sel,
                       input logic push, input exp_t e);
    drive(d, 1'b1, a, b, sel);
    e.cyc = cyc + 1 + nsl(d);
    if (push) begin
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
    drive(d, 1'b0, ~a, b ^ 16'h5A5A, ~sel);
  endtask

  task automatic wait_done(input int d, input int budget);
    int n;
    logic dn;
    n = 0;
    dn = 1'b0;
    while (!dn && n < budget) begin
      @(negedge clk);
      n++;
      dn = get_done(d);
    end
    if (!dn) chk($sformatf("u%0d_done_timeout", d), 32'(dn), 32'd1);
  endtask

  task automatic mon(input int d, input logic dn, input logic [15:0] s, input logic c,
                     input logic o, input logic z);
    exp_t e;
    int sz;
    if (dn) begin
      case (d)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
      if (sz == 0) begin
        chk($sformatf("u%0d_unexpected_done", d), 32'd1, 32'd0);
      end else begin
        case (d)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("u%0d_S", d), 32'(s), 32'(e.s));
        chk($sformatf("u%0d_cout", d), 32'(c), 32'(e.c));
        chk($sformatf("u%0d_ovf", d), 32'(o), 32'(e.o));
        chk($sformatf("u%0d_zero", d), 32'(z), 32'(e.z));
        chk($sformatf("u%0d_done_cycle", d), 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.done, if0.s, if0.cout, if0.ovf, if0.zero);
    mon(1, if1.done, if1.s, if1.cout, if1.ovf, if1.zero);
    mon(2, if2.done, if2.s, if2.cout, if2.ovf, if2.zero);
    if (if0.busy) chk("u0_S_hold_while_busy", 32'(if0.s), 32'(hold_s));
    hold_s <= if0.s;
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(if0.busy), 32'd0);
    chk({tag, "_done"}, 32'(if0.done), 32'd0);
    chk({tag, "_S"},    32'(if0.s),    32'd0);
    chk({tag, "_cout"}, 32'(if0.cout), 32'd0);
    chk({tag, "_ovf"},  32'(if0.ovf),  32'd0);
    chk({tag, "_zero"}, 32'(if0.zero), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Directed vectors, hand-computed.
    @(negedge clk);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    wait_done(0, 20);
    @(negedge clk);
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    wait_done(0, 20);
    // Back-to-back: start presented during the DONE cycle.
    issue(0, 16'h0000, 16'h0001, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
    wait_done(0, 20);
    @(negedge clk);
    issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    wait_done(0, 20);
    @(negedge clk);
    issue(0, 16'h1234, 16'h1234, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    wait_done(0, 20);
    @(negedge clk);
    issue(0, 16'h8000, 16'h8000, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b1));
    wait_done(0, 20);

    // start with new operands during RUN must be ignored.
    @(negedge clk);
    issue(0, 16'h0102, 16'h0304, 1'b0, 1'b1, mk(16'h0406, 1'b0, 1'b0, 1'b0));
    drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_done(0, 20);
    @(negedge clk);
    chk("u0_no_queued_op_busy", 32'(if0.busy), 32'd0);
    chk("u0_single_done", 32'(if0.done), 32'd0);

    // Reset during the second RUN cycle aborts without a result.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", 32'(if0.busy), 32'd0);
    issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b1, mk(16'h0100, 1'b0, 1'b0, 1'b0));
    wait_done(0, 20);

    // Bit-serial and single-cycle variants against the reference model.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [15:0] a1, b1;
          logic s1;
          a1 = (i < 6) ? dir_a[i] : 16'($urandom);
          b1 = (i < 6) ? dir_b[i] : 16'($urandom);
          s1 = (i < 6) ? dir_s[i] : 1'($urandom);
          @(negedge clk);
          issue(1, a1, b1, s1, 1'b1, model(a1, b1, s1));
          wait_done(1, 40);
        end
      end
      begin
        for (int j = 0; j < 200; j++) begin
          logic [15:0] a2, b2;
          logic s2;
          a2 = (j < 6) ? dir_a[j] : 16'($urandom);
          b2 = (j < 6) ? dir_b[j] : 16'($urandom);
          s2 = (j < 6) ? dir_s[j] : 1'($urandom);
          issue(2, a2, b2, s2, 1'b1, model(a2, b2, s2));
          wait_done(2, 10);
        end
      end
    join

    repeat (3) @(negedge clk);
    chk("u0_queue_drained", 32'(q0.size()), 32'd0);
    chk("u1_queue_drained", 32'(q1.size()), 32'd0);
    chk("u2_queue_drained", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
